inst_mem_loader: RTL and testbench
==================================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: instruction memory capacity in 32-bit words.
REQ-002 Parameter CNT_W, default 9: width of word_count, which SHALL hold 0..DEPTH_WORDS.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  level/pulse; sampled only in IDLE or DONE; begins a load.
REQ-006 byte_valid  input  1  byte_data is valid this cycle.
REQ-007 byte_data  input  8  program byte stream, big-endian within each word.
REQ-008 byte_last  input  1  qualifies the final byte of the stream.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-011 mem_addr  output  32  byte address, word aligned (word_count*4), matching the PC addressing.
REQ-012 mem_wdata  output  32  assembled instruction word.
REQ-013 cpu_hold  output  1  holds the pipeline PC and stage buffers while high.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  load finished; stays high until the next start.
REQ-016 err  output  1  overflow or checksum failure of the last load.
REQ-017 word_count  output  CNT_W  words written in the current or last load.

Function
REQ-018 States SHALL be IDLE, COLLECT, WRITE and DONE, plus CHECK only when the macro is defined.
REQ-019 A byte SHALL be accepted exactly when byte_valid and byte_ready are both high, and byte_ready SHALL be high only in COLLECT.
REQ-020 IDLE/DONE + start -> COLLECT: byte index, word_count and err SHALL clear, done SHALL clear, and cpu_hold and busy SHALL be set.
REQ-021 Accepted byte k of a word (k=0..3) SHALL land in mem_wdata bits [31-8k:24-8k].
REQ-022 After the 4th accepted byte, the FSM SHALL be in WRITE on the next cycle; mem_we SHALL be high for exactly that one cycle with mem_addr = word_count*4.
REQ-023 word_count SHALL increment by 1 on every WRITE cycle.
REQ-024 byte_last accepted at k<3 SHALL zero-fill the remaining low bytes and enter WRITE.
REQ-025 WRITE -> DONE if the word held last, otherwise WRITE -> COLLECT with byte index 0.
REQ-026 Peak throughput SHALL be one word per 5 cycles.
REQ-027 A WRITE that makes word_count = DEPTH_WORDS without last SHALL set err=1 and enter DONE; later bytes SHALL not be accepted.
REQ-028 DONE: done=1, busy=0, cpu_hold=0; word_count and err SHALL hold.
REQ-029 start SHALL be ignored in COLLECT, WRITE and CHECK.
REQ-030 mem_we SHALL be low in every state except WRITE, and mem_addr/mem_wdata SHALL hold between writes.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, word_count=0, cpu_hold=1.
REQ-032 Reset mid-load SHALL abandon the partial word with no write, and cpu_hold SHALL stay 1 until a later load completes.

Configuration
REQ-033 Macro LOADER_CHECKSUM_EN defined: the byte with byte_last is an XOR checksum, not payload.
REQ-034 It SHALL close the current partial word (zero-filled) and that word SHALL be written; if the checksum arrives at k=0, no extra word SHALL be written.
REQ-035 The FSM SHALL then pass through one CHECK cycle before DONE, setting err=1 if the XOR of all payload bytes differs from the checksum.
REQ-036 Macro undefined: no CHECK state, all bytes are payload, and err SHALL signal overflow only.

Verification
REQ-037 Reset then start, 8 back-to-back bytes 20 08 00 05 / 8C 09 00 04 with last on byte 8 -> writes 0x20080005 at addr 0 and 0x8C090004 at addr 4; done=1, word_count=2, cpu_hold=0.
REQ-038 Bytes AA BB with last on BB (macro off) -> single write 0xAABB0000 at addr 0; word_count=1.
REQ-039 DEPTH_WORDS=2, 12 bytes, no last -> 2 writes, err=1, byte_ready stays 0 after the 8th byte.
REQ-040 byte_valid toggling 1/0 every cycle -> same words as REQ-037; mem_we pulses exactly twice.
REQ-041 rst_n=0 after 3 accepted bytes -> no mem_we, IDLE, cpu_hold=1; a new start reloads from addr 0.
REQ-042 Macro on: 01 02 03 04 then checksum 04 -> word 0x01020304, err=0; with checksum 05 -> err=1.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 32-bit words and holds the CPU meanwhile.
// Optional LOADER_CHECKSUM_EN: the byte flagged last is an XOR checksum verified in a CHECK state.
module inst_mem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int CNT_W       = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             byte_last,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] word_count
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE, S_CHECK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      wbuf_q, wbuf_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       xacc_q, xacc_d;
  logic [7:0]       csum_q, csum_d;
`endif

  logic        accept;
  logic [31:0] word_ins;
  logic [31:0] cnt_addr;

  assign accept   = byte_valid && (state_q == S_COLLECT);
  assign cnt_addr = 32'(cnt_q) << 2;
  // Byte k lands at [31-8k:24-8k]; the first byte of a word clears the rest so short words are zero-filled.
  assign word_ins = ((idx_q == 2'd0) ? 32'h0 : wbuf_q)
                  | ({24'h0, byte_data} << (5'd24 - {idx_q, 3'b000}));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wbuf_d  = wbuf_q;
`ifdef LOADER_CHECKSUM_EN
    xacc_d  = xacc_q;
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_COLLECT;
          idx_d   = 2'd0;
          last_d  = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          xacc_d  = 8'h0;
`endif
        end
      end
      S_COLLECT: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          if (byte_last) begin
            csum_d = byte_data;
            last_d = 1'b1;
            if (idx_q == 2'd0) begin
              state_d = S_CHECK;
            end else begin
              wdata_d = wbuf_q;
              addr_d  = cnt_addr;
              state_d = S_WRITE;
            end
          end else begin
            xacc_d = xacc_q ^ byte_data;
            wbuf_d = word_ins;
            idx_d  = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              wdata_d = word_ins;
              addr_d  = cnt_addr;
              state_d = S_WRITE;
            end
          end
`else
          wbuf_d = word_ins;
          idx_d  = idx_q + 2'd1;
          last_d = byte_last;
          if (byte_last || idx_q == 2'd3) begin
            wdata_d = word_ins;
            addr_d  = cnt_addr;
            state_d = S_WRITE;
          end
`endif
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = 2'd0;
        if (last_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else if (cnt_q == CNT_W'(DEPTH_WORDS - 1)) begin
          // Memory full with more program still pending: flag overflow and stop accepting.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        err_d   = (xacc_q != csum_q);
        state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Assembly buffer needs no reset: the byte index restarts at 0, which clears it on first use.
  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
`ifdef LOADER_CHECKSUM_EN
    xacc_q <= xacc_d;
    csum_q <= csum_d;
`endif
  end

  assign byte_ready = (state_q == S_COLLECT);
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign cpu_hold   = (state_q != S_DONE);
  assign err        = err_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: a stream-level model queues expected writes, a monitor checks them.
module tb_inst_mem_loader;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            byte_valid = 1'b0;
  logic [7:0]      byte_data = 8'h0;
  logic            byte_last = 1'b0;
  logic            byte_ready, mem_we, cpu_hold, busy, done, err;
  logic [31:0]     mem_addr, mem_wdata;
  logic [CW-1:0]   word_count;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  inst_mem_loader #(.DEPTH_WORDS(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
      end
    end
  end

  // Stream-level reference: words are groups of four payload bytes, zero-filled; memory holds DEPTH words.
  task automatic model(input logic [7:0] s[$], input bit has_last, output int n_acc,
                       output bit m_err, output bit m_ovf, output int m_wc,
                       output logic [31:0] m_addr, output logic [31:0] m_data);
    logic [7:0]  pay[$];
    bit          ck_err;
    int          full;
    logic [31:0] w;
    pay = s;
    ck_err = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    if (has_last) begin
      logic [7:0] x;
      logic [7:0] cs;
      cs = pay.pop_back();
      x = 8'h0;
      foreach (pay[i]) x = x ^ pay[i];
      ck_err = (x != cs);
    end
`endif
    full  = has_last ? (s.size() - 1) / 4 : s.size() / 4;
    m_ovf = (full >= DEPTH);
    m_wc  = m_ovf ? DEPTH : (pay.size() + 3) / 4;
    n_acc = m_ovf ? 4 * DEPTH : s.size();
    m_err = m_ovf ? 1'b1 : ck_err;
    m_addr = 32'h0;
    m_data = 32'h0;
    for (int k = 0; k < m_wc; k++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * k + b < pay.size()) w[31 - 8 * b -: 8] = pay[4 * k + b];
      exp_q.push_back('{addr: 32'(4 * k), data: w});
      m_addr = 32'(4 * k);
      m_data = w;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_wc"}, 32'(word_count), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
  endtask

  // All drive tasks start and end at 1 time unit after a rising edge.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_hold", 32'(cpu_hold), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_wc", 32'(word_count), 32'd0);
    chk("start_err", 32'(err), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l, input logic st);
    int   t;
    logic acc;
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = l;
    start      = st;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 100) begin
      acc = byte_ready;
      @(posedge clk); #1;
      t++;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    start      = 1'b0;
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic run_load(input logic [7:0] s[$], input bit has_last, input int gap_mode);
    int          n_acc, m_wc, t, gap;
    bit          m_err, m_ovf;
    logic [31:0] m_addr, m_data;
    model(s, has_last, n_acc, m_err, m_ovf, m_wc, m_addr, m_data);
    do_start();
    for (int i = 0; i < n_acc; i++) begin
      send_byte(s[i], 1'(has_last && (i == s.size() - 1)), 1'($urandom_range(0, 1)));
      gap = (gap_mode == 0) ? int'($urandom_range(0, 2)) : (gap_mode == 1) ? 1 : 0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("end_done", 32'(done), 32'd1);
    chk("end_err", 32'(err), 32'(m_err));
    chk("end_wc", 32'(word_count), 32'(m_wc));
    chk("end_hold", 32'(cpu_hold), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_ready", 32'(byte_ready), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    if (m_wc > 0) begin
      chk("hold_addr", mem_addr, m_addr);
      chk("hold_wdata", mem_wdata, m_data);
    end
    if (m_ovf) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      repeat (4) begin
        chk("ovf_ready", 32'(byte_ready), 32'd0);
        @(posedge clk); #1;
      end
      byte_valid = 1'b0;
      chk("ovf_wc", 32'(word_count), 32'(DEPTH));
    end
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    bit         hl;
    int         n;

    repeat (3) @(posedge clk);
    #1;
    check_reset("rst0");
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("idle_hold", 32'(cpu_hold), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    s = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    run_load(s, 1'b1, 2);
    run_load(s, 1'b1, 1);
    s = '{8'hAA, 8'hBB};
    run_load(s, 1'b1, 2);
    s.delete();
    for (int i = 0; i < 4 * DEPTH + 4; i++) s.push_back(8'($urandom));
    run_load(s, 1'b0, 2);
    s.delete();
    for (int i = 0; i < 4 * DEPTH; i++) s.push_back(8'($urandom));
    run_load(s, 1'b1, 0);
`ifdef LOADER_CHECKSUM_EN
    s = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_load(s, 1'b1, 2);
    s = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load(s, 1'b1, 2);
`endif

    // Reset in the middle of a word abandons it.
    do_start();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset("rstmid");
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rstmid_sb", 32'(exp_q.size()), 32'd0);
    s = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    run_load(s, 1'b1, 2);

    for (int r = 0; r < 30; r++) begin
      hl = ($urandom_range(0, 3) != 0);
      n  = hl ? int'($urandom_range(1, 4 * DEPTH + 4)) : 4 * DEPTH + int'($urandom_range(0, 4));
      s.delete();
      for (int i = 0; i < n; i++) s.push_back(8'($urandom));
      run_load(s, hl, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
